// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 key event queue.
// Turns raw scancode bytes into make/break events, handling the E0 and F0
// prefixes. Typematic repeats are dropped and events are buffered in a
// first-word-fall-through FIFO. Also tracks which arrow keys are held and
// the most recent key code.
module ps2_key_event_queue #(
    parameter int DEPTH           = 8,
    parameter int ADDR_W          = 3,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              pop,
    input  logic              clear_overflow,
    output logic              event_valid,
    output logic [7:0]        event_code,
    output logic              event_extended,
    output logic              event_release,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow,
    output logic [3:0]        arrows_held,
    output logic [7:0]        last_code
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  TO_MAX    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic               trk_vld_q, trk_vld_d;
    logic               trk_ext_q, trk_ext_d;
    logic [7:0]         trk_code_q, trk_code_d;
    logic [7:0]         last_code_q, last_code_d;
    logic [3:0]         arrows_q, arrows_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [9:0]         mem_q [DEPTH];

    logic               is_discard;
    logic               ev_form, ev_ext, ev_rel;
    logic               trk_hit, ev_drop, ev_ok;
    logic               full_w, push_ok, pop_ok, push_drop;

    // Prefix decoder: walks E0/F0 prefixes, forms an event on the final byte,
    // and abandons a stalled prefix after the idle timeout.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        ev_form    = 1'b0;
        ev_ext     = 1'b0;
        ev_rel     = 1'b0;
        is_discard = byte_data inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
        if (byte_valid) begin
            to_cnt_d = '0;
            if (is_discard) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (byte_data == 8'hE0)      state_d = GOT_E0;
                        else if (byte_data == 8'hF0) state_d = GOT_F0;
                        else                         ev_form = 1'b1;
                    end
                    GOT_E0: begin
                        if (byte_data == 8'hF0)      state_d = GOT_E0F0;
                        else if (byte_data != 8'hE0) begin
                            ev_form = 1'b1;
                            ev_ext  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    GOT_F0: begin
                        if (byte_data == 8'hE0)      state_d = GOT_E0;
                        else if (byte_data != 8'hF0) begin
                            ev_form = 1'b1;
                            ev_rel  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        if (byte_data != 8'hE0 && byte_data != 8'hF0) begin
                            ev_form = 1'b1;
                            ev_ext  = 1'b1;
                            ev_rel  = 1'b1;
                        end
                    end
                endcase
            end
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TO_MAX) begin
                state_d  = IDLE;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Repeat filter, arrow bitmap and last-code capture for formed events.
    always_comb begin
        trk_vld_d   = trk_vld_q;
        trk_ext_d   = trk_ext_q;
        trk_code_d  = trk_code_q;
        last_code_d = last_code_q;
        arrows_d    = arrows_q;
        trk_hit     = trk_vld_q && (trk_ext_q == ev_ext) && (trk_code_q == byte_data);
        ev_drop     = (SUPPRESS_REPEAT != 0) && ev_form && !ev_rel && trk_hit;
        ev_ok       = ev_form && !ev_drop;
        if (ev_ok && !ev_rel) begin
            trk_vld_d  = 1'b1;
            trk_ext_d  = ev_ext;
            trk_code_d = byte_data;
        end else if (ev_form && ev_rel && trk_hit) begin
            trk_vld_d = 1'b0;
        end
        if (ev_ok) begin
            last_code_d = byte_data;
            if (ev_ext) begin
                case (byte_data)
                    8'h75:   arrows_d[3] = !ev_rel;
                    8'h72:   arrows_d[2] = !ev_rel;
                    8'h6B:   arrows_d[1] = !ev_rel;
                    8'h74:   arrows_d[0] = !ev_rel;
                    default: ;
                endcase
            end
        end
    end

    // FIFO bookkeeping: a push while full is accepted only alongside a pop.
    always_comb begin
        full_w     = (count_q == DEPTH_CNT);
        pop_ok     = pop && (count_q != '0);
        push_ok    = ev_ok && (!full_w || pop);
        push_drop  = ev_ok && full_w && !pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop_ok);
        overflow_d = (overflow_q && !clear_overflow) || push_drop;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            trk_vld_q   <= 1'b0;
            trk_ext_q   <= 1'b0;
            trk_code_q  <= '0;
            last_code_q <= '0;
            arrows_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            trk_vld_q   <= trk_vld_d;
            trk_ext_q   <= trk_ext_d;
            trk_code_q  <= trk_code_d;
            last_code_q <= last_code_d;
            arrows_q    <= arrows_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Event storage {ext, rel, code}; contents need no reset.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) mem_q[wr_ptr_q] <= {ev_ext, ev_rel, byte_data};
    end

    assign event_valid    = (count_q != '0);
    assign event_extended = mem_q[rd_ptr_q][9];
    assign event_release  = mem_q[rd_ptr_q][8];
    assign event_code     = mem_q[rd_ptr_q][7:0];
    assign count          = count_q;
    assign full           = full_w;
    assign overflow       = overflow_q;
    assign arrows_held    = arrows_q;
    assign last_code      = last_code_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_ps2_key_event_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int T     = 16;

    logic          clock, reset, byte_valid, pop, clear_overflow;
    logic [7:0]    byte_data;
    logic          event_valid, event_extended, event_release, full, overflow;
    logic [7:0]    event_code, last_code;
    logic [AW:0]   count;
    logic [3:0]    arrows_held;

    ps2_key_event_queue #(
        .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYCLES(T), .SUPPRESS_REPEAT(1)
    ) dut (
        .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .pop(pop), .clear_overflow(clear_overflow), .event_valid(event_valid),
        .event_code(event_code), .event_extended(event_extended),
        .event_release(event_release), .count(count), .full(full),
        .overflow(overflow), .arrows_held(arrows_held), .last_code(last_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] q[$];
    bit         pend_ext, pend_rel;
    int         cyc, last_byte_cyc;
    bit         trk_v;
    logic [8:0] trk;
    logic [7:0] m_last;
    logic [3:0] m_arrows;
    bit         m_ovf;

    always @(posedge clock) begin
        bit         got, drop;
        logic [9:0] ev;
        logic [7:0] b;
        cyc++;
        got  = 0;
        drop = 0;
        ev   = '0;
        if (reset) begin
            q.delete();
            pend_ext = 0; pend_rel = 0;
            trk_v = 0; m_last = '0; m_arrows = '0; m_ovf = 0;
        end else begin
            if (byte_valid) begin
                b = byte_data;
                // a prefix left idle for more than T cycles is forgotten
                if ((pend_ext || pend_rel) && (cyc - last_byte_cyc > T)) begin
                    pend_ext = 0; pend_rel = 0;
                end
                last_byte_cyc = cyc;
                if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1}) begin
                    pend_ext = 0; pend_rel = 0;
                end else if (b == 8'hE0) begin
                    if (pend_ext && pend_rel) begin pend_ext = 0; pend_rel = 0; end
                    else begin pend_ext = 1; pend_rel = 0; end
                end else if (b == 8'hF0) begin
                    if (pend_ext && pend_rel) begin pend_ext = 0; pend_rel = 0; end
                    else pend_rel = 1;
                end else begin
                    ev = {pend_ext, pend_rel, b};
                    got = 1;
                    pend_ext = 0; pend_rel = 0;
                end
            end
            if (got) begin
                if (!ev[8]) begin
                    if (trk_v && trk == {ev[9], ev[7:0]}) got = 0;
                    else begin trk_v = 1; trk = {ev[9], ev[7:0]}; end
                end else if (trk_v && trk == {ev[9], ev[7:0]}) begin
                    trk_v = 0;
                end
            end
            if (got) begin
                m_last = ev[7:0];
                if (ev[9]) begin
                    case (ev[7:0])
                        8'h75: m_arrows[3] = !ev[8];
                        8'h72: m_arrows[2] = !ev[8];
                        8'h6B: m_arrows[1] = !ev[8];
                        8'h74: m_arrows[0] = !ev[8];
                        default: ;
                    endcase
                end
            end
            if (pop && q.size() > 0) void'(q.pop_front());
            if (got) begin
                if (q.size() < DEPTH) q.push_back(ev);
                else drop = 1;
            end
            m_ovf = (m_ovf && !clear_overflow) || drop;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (started) begin
            chk("count", count, q.size());
            chk("event_valid", event_valid, q.size() > 0);
            chk("full", full, q.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("arrows_held", arrows_held, m_arrows);
            chk("last_code", last_code, m_last);
            if (q.size() > 0)
                chk("head", {event_extended, event_release, event_code}, q[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        byte_valid = 1; byte_data = b; pop = p;
        @(negedge clock);
        byte_valid = 0; pop = 0;
    endtask

    task automatic do_pop();
        pop = 1;
        @(negedge clock);
        pop = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] arr [4];
        logic [7:0] dis [6];
        arr = '{8'h75, 8'h72, 8'h6B, 8'h74};
        dis = '{8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
        case ($urandom_range(0, 9))
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4, 5:    return arr[$urandom_range(0, 3)];
            6:       return dis[$urandom_range(0, 5)];
            7:       return 8'h1C;
            8:       return 8'h10 + 8'($urandom_range(0, 7));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        reset = 1; byte_valid = 0; byte_data = '0; pop = 0; clear_overflow = 0;
        @(negedge clock);
        reset = 0;
        started = 1;
        chk("reset count", count, 0);
        chk("reset valid", event_valid, 0);
        chk("reset arrows", arrows_held, 0);
        chk("reset last_code", last_code, 0);

        // make / break of a plain key
        send(8'h1D, 0); send(8'hF0, 0); send(8'h1D, 0);
        chk("t1 count", count, 2);
        chk("t1 last_code", last_code, 8'h1D);
        chk("t1 arrows", arrows_held, 0);
        chk("t1 head0", {event_extended, event_release, event_code}, 10'h01D);
        do_pop();
        chk("t1 head1", {event_extended, event_release, event_code}, 10'h11D);
        do_pop();

        // extended arrow make/break
        do_reset();
        send(8'hE0, 0); send(8'h75, 0);
        chk("t2 arrows up", arrows_held, 4'b1000);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        chk("t2 arrows clr", arrows_held, 4'b0000);
        chk("t2 head0", {event_extended, event_release, event_code}, 10'h275);
        do_pop();
        chk("t2 head1", {event_extended, event_release, event_code}, 10'h375);
        do_pop();
        chk("t2 valid", event_valid, 0);
        chk("t2 count", count, 0);

        // typematic repeat suppression
        do_reset();
        send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0);
        send(8'hF0, 0); send(8'h1C, 0); send(8'h1C, 0);
        chk("t3 count", count, 3);
        chk("t3 head0", {event_extended, event_release, event_code}, 10'h01C);
        do_pop();
        chk("t3 head1", {event_extended, event_release, event_code}, 10'h11C);
        do_pop();
        chk("t3 head2", {event_extended, event_release, event_code}, 10'h01C);

        // fill past capacity
        do_reset();
        for (int i = 0; i <= DEPTH; i++) send(8'h10 + 8'(i), 0);
        chk("t4 full", full, 1);
        chk("t4 count", count, 8);
        chk("t4 overflow", overflow, 1);
        chk("t4 head", {event_extended, event_release, event_code}, 10'h010);
        send(8'h19, 1);
        chk("t4 count pp", count, 8);
        chk("t4 ovf pp", overflow, 1);
        chk("t4 head pp", {event_extended, event_release, event_code}, 10'h011);
        clear_overflow = 1;
        @(negedge clock);
        clear_overflow = 0;
        chk("t4 ovf clr", overflow, 0);

        // prefix timeout: one cycle short keeps E0, full timeout drops it
        do_reset();
        send(8'hE0, 0); idle(T - 1); send(8'h6B, 0);
        chk("t5a head", {event_extended, event_release, event_code}, 10'h26B);
        chk("t5a arrows", arrows_held, 4'b0010);
        do_reset();
        send(8'hE0, 0); idle(T); send(8'h6B, 0);
        chk("t5b head", {event_extended, event_release, event_code}, 10'h06B);
        chk("t5b arrows", arrows_held, 0);

        // reset in the middle of a prefix
        do_reset();
        send(8'hE0, 0); send(8'hF0, 0);
        do_reset();
        send(8'h74, 0);
        chk("t6 count", count, 1);
        chk("t6 head", {event_extended, event_release, event_code}, 10'h074);
        chk("t6 overflow", overflow, 0);

        // randomized traffic; pop rate rises in the second half
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            reset          = (r == 0);
            byte_valid     = ($urandom_range(0, 2) == 0);
            byte_data      = pick_byte();
            pop            = (i < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            @(negedge clock);
            if (r >= 194) begin
                reset = 0; byte_valid = 0; pop = 0; clear_overflow = 0;
                idle(T - 2 + int'($urandom_range(0, 4)));
            end
        end
        reset = 0; byte_valid = 0; pop = 0; clear_overflow = 0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
